decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 32: register, immediate and write-data width; legal 16..64.
REQ-002 Parameter NUM_REGS, default 32: register-file depth; legal 2..32.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1: asynchronous, active-low reset.
REQ-005 Port in_valid  in  1: instruction word valid this cycle.
REQ-006 Port in_ready  out  1: stage can accept an instruction this cycle.
REQ-007 Port instruction  in  26: fields rs[25:21], rt[20:16], rd[15:11], imm[15:0], func[5:0].
REQ-008 Port reg_dst  in  1: 1 selects rd, 0 selects rt, as destination index.
REQ-009 Port imm_signed  in  1: 1 sign-extends imm, 0 zero-extends imm.
REQ-010 Port wr_en  in  1: register-file write enable.
REQ-011 Port wr_addr  in  5: register-file write index.
REQ-012 Port wr_data  in  DATA_W: register-file write data.
REQ-013 Port out_valid  out  1: decoded bundle valid.
REQ-014 Port out_ready  in  1: downstream accepts the bundle.
REQ-015 Port read_data0 / read_data1  out  DATA_W each: rs / rt operand values.
REQ-016 Port imm_ext  out  DATA_W: extended immediate.
REQ-017 Port dest_reg  out  5: selected destination index.
REQ-018 Port func  out  6: function field.
REQ-019 Port io_registers  out  NUM_REGS*DATA_W: register file, flattened, entry i at bits [i*DATA_W +: DATA_W].

Function
REQ-020 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-021 Accept occurs when in_valid && in_ready; the stage SHALL register operands, imm_ext, dest_reg and func at that edge, with out_valid=1 from the next cycle (latency 1).
REQ-022 If out_valid && out_ready and no accept, out_valid SHALL go 0 next cycle; outputs hold their last values.
REQ-023 While out_valid && !out_ready, all bundle outputs SHALL stay stable.
REQ-024 Simultaneous drain and accept SHALL replace the bundle with no bubble, out_valid staying 1.
REQ-025 Register 0 SHALL always read 0; writes to it SHALL be ignored.
REQ-026 Any read index >= NUM_REGS SHALL return 0; writes with wr_addr >= NUM_REGS SHALL be ignored.
REQ-027 Writes SHALL occur at the rising edge when wr_en=1, independent of the handshake.
REQ-028 Operands SHALL be sampled from the register file at the accept edge; later writes SHALL not alter a held bundle.
REQ-029 imm_ext SHALL be the imm field extended to DATA_W per imm_signed at accept time.
REQ-030 io_registers SHALL reflect register-file contents, updated one edge after a write.

Reset
REQ-031 When reset is low, out_valid, read_data0, read_data1, imm_ext, dest_reg, func and all register entries SHALL be 0 immediately, regardless of clk.
REQ-032 A bundle held at reset assertion SHALL be discarded; the first accept after release SHALL behave as from idle.

Configuration
REQ-033 Macro DECODE_BYPASS_EN defined: on accept with wr_en=1 and a valid nonzero wr_addr equal to rs (or rt), the captured operand SHALL be wr_data.
REQ-034 Macro DECODE_BYPASS_EN undefined: the captured operand SHALL be the pre-write register value; the write still completes.

Verification
REQ-035 Write r5=0x0000_1234, then accept rs=5, rt=0 -> next cycle out_valid=1, read_data0=0x1234, read_data1=0.
REQ-036 Accept imm=0x8001 with imm_signed=1, then with 0 -> imm_ext=0xFFFF_8001, then 0x0000_8001 (DATA_W=32).
REQ-037 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and bundle stable; out_ready=1 -> new bundle next cycle, no bubble.
REQ-038 Same-cycle wr_en, wr_addr=7, wr_data=0xDEAD_BEEF and accept rs=7 -> read_data0=0xDEADBEEF with DECODE_BYPASS_EN, old r7 without.
REQ-039 NUM_REGS=16: write r20=5 and r0=9, read both -> both 0; pull reset low while out_valid=1 -> out_valid=0 and io_registers all 0 before the next edge.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: single-entry decode pipeline stage with an integrated register file.
// Captures rs/rt operands, the extended immediate, the destination index and the
// function field on accept, and holds them under a valid/ready handshake.
// Optional feature macro: DECODE_BYPASS_EN -- a register write that lands on the
// same edge as an accept is forwarded into the captured operands.
module decode_stage #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [25:0]                  instruction,
   input  logic                         reg_dst,
   input  logic                         imm_signed,
   input  logic                         wr_en,
   input  logic [4:0]                   wr_addr,
   input  logic [DATA_W-1:0]            wr_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            read_data0,
   output logic [DATA_W-1:0]            read_data1,
   output logic [DATA_W-1:0]            imm_ext,
   output logic [4:0]                   dest_reg,
   output logic [5:0]                   func,
   output logic [NUM_REGS*DATA_W-1:0]   io_registers
);

   logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
   logic                            r_valid;
   logic [DATA_W-1:0]               r_op0;
   logic [DATA_W-1:0]               r_op1;
   logic [DATA_W-1:0]               r_imm;
   logic [4:0]                      r_dest;
   logic [5:0]                      r_func;

   logic [4:0]                      w_rs;
   logic [4:0]                      w_rt;
   logic [15:0]                     w_imm;
   logic [DATA_W-1:0]               w_rf_rs;
   logic [DATA_W-1:0]               w_rf_rt;
   logic                            w_wr_hit;
   logic                            w_accept;
   logic [DATA_W-1:0]               w_op0;
   logic [DATA_W-1:0]               w_op1;

   assign w_rs     = instruction[25:21];
   assign w_rt     = instruction[20:16];
   assign w_imm    = instruction[15:0];
   assign in_ready = !r_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   // Register-file read ports and write-address qualification; entry 0 and
   // indices beyond the file never match, so they read 0 and drop writes.
   always_comb begin
      w_rf_rs  = '0;
      w_rf_rt  = '0;
      w_wr_hit = 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (w_rs == 5'(i))    w_rf_rs  = r_regs[i];
         if (w_rt == 5'(i))    w_rf_rt  = r_regs[i];
         if (wr_addr == 5'(i)) w_wr_hit = wr_en;
      end
   end

`ifdef DECODE_BYPASS_EN
   assign w_op0 = (w_wr_hit && (wr_addr == w_rs)) ? wr_data : w_rf_rs;
   assign w_op1 = (w_wr_hit && (wr_addr == w_rt)) ? wr_data : w_rf_rt;
`else
   assign w_op0 = w_rf_rs;
   assign w_op1 = w_rf_rt;
`endif

   // Register-file write port, independent of the decode handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_regs <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (w_wr_hit && (wr_addr == 5'(i))) r_regs[i] <= wr_data;
         end
      end
   end

   // Output bundle: capture on accept, drop valid on drain, hold otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_op0   <= '0;
         r_op1   <= '0;
         r_imm   <= '0;
         r_dest  <= '0;
         r_func  <= '0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_op0   <= w_op0;
         r_op1   <= w_op1;
         r_imm   <= {{(DATA_W-16){imm_signed & w_imm[15]}}, w_imm};
         r_dest  <= reg_dst ? instruction[15:11] : w_rt;
         r_func  <= instruction[5:0];
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid    = r_valid;
   assign read_data0   = r_op0;
   assign read_data1   = r_op1;
   assign imm_ext      = r_imm;
   assign dest_reg     = r_dest;
   assign func         = r_func;
   assign io_registers = r_regs;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage (DATA_W=32, NUM_REGS=16): a behavioural model of the
// stage plus register file is checked against the DUT on every falling edge,
// alongside hand-computed literal expectations for the directed scenarios.
module tb_decode_stage;
   localparam int DW    = 32;
   localparam int NREGS = 16;
   localparam int FW    = NREGS * DW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [25:0]   instruction = '0;
   logic          reg_dst = 1'b0;
   logic          imm_signed = 1'b0;
   logic          wr_en = 1'b0;
   logic [4:0]    wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] read_data0, read_data1, imm_ext;
   logic [4:0]    dest_reg;
   logic [5:0]    func;
   logic [FW-1:0] io_registers;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   decode_stage #(.DATA_W(DW), .NUM_REGS(NREGS)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .reg_dst(reg_dst), .imm_signed(imm_signed),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .read_data0(read_data0), .read_data1(read_data1), .imm_ext(imm_ext),
      .dest_reg(dest_reg), .func(func), .io_registers(io_registers)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_rf [32];
   bit            m_valid = 0;
   logic [DW-1:0] m_op0 = '0, m_op1 = '0, m_imm = '0;
   logic [4:0]    m_dest = '0;
   logic [5:0]    m_func = '0;

   initial for (int i = 0; i < 32; i++) m_rf[i] = '0;

   function automatic logic [DW-1:0] model_read(input int idx);
      if (idx == 0 || idx >= NREGS) return '0;
`ifdef DECODE_BYPASS_EN
      if (wr_en && int'(wr_addr) == idx) return wr_data;
`endif
      return m_rf[idx];
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_valid = 0; m_op0 = '0; m_op1 = '0; m_imm = '0; m_dest = '0; m_func = '0;
         for (int i = 0; i < 32; i++) m_rf[i] = '0;
      end else begin
         if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1;
            m_op0   = model_read(int'(instruction[25:21]));
            m_op1   = model_read(int'(instruction[20:16]));
            m_imm   = imm_signed ? DW'($signed(instruction[15:0])) : DW'(instruction[15:0]);
            m_dest  = reg_dst ? instruction[15:11] : instruction[20:16];
            m_func  = instruction[5:0];
         end else if (out_ready) begin
            m_valid = 0;
         end
         if (wr_en && wr_addr != 0 && int'(wr_addr) < NREGS) m_rf[wr_addr] = wr_data;
      end
   end

   // Continuous compare on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [FW-1:0] exp_rf;
         for (int i = 0; i < NREGS; i++) exp_rf[i*DW +: DW] = m_rf[i];
         check("in_ready",     FW'(in_ready),   FW'(!m_valid || out_ready));
         check("out_valid",    FW'(out_valid),  FW'(m_valid));
         check("read_data0",   FW'(read_data0), FW'(m_op0));
         check("read_data1",   FW'(read_data1), FW'(m_op1));
         check("imm_ext",      FW'(imm_ext),    FW'(m_imm));
         check("dest_reg",     FW'(dest_reg),   FW'(m_dest));
         check("func",         FW'(func),       FW'(m_func));
         check("io_registers", io_registers,    exp_rf);
      end
   end

   // ---------------- stimulus ----------------
   task automatic next();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   function automatic logic [25:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
      return {rs, rt, imm};
   endfunction

   task automatic wr(input logic [4:0] a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      next();
      wr_en = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] exp_bypass;
      next();
      chk_en = 1'b1;
      check("reset_out_valid", FW'(out_valid), FW'(0));
      check("reset_regs", io_registers, '0);
      reset = 1'b1;
      next();

      // r5 = 0x1234, then rs=5, rt=0
      wr(5'd5, 32'h0000_1234);
      reg_dst = 1'b1; instruction = mk(5'd5, 5'd0, 16'h1825); in_valid = 1'b1;
      next();
      in_valid = 1'b0;
      check("lit_valid_lat1", FW'(out_valid),  FW'(1));
      check("lit_rd0_r5",     FW'(read_data0), FW'(32'h0000_1234));
      check("lit_rd1_r0",     FW'(read_data1), FW'(0));
      check("lit_dest_rd",    FW'(dest_reg),   FW'(5'd3));
      check("lit_func",       FW'(func),       FW'(6'h25));

      // Immediate extension, back-to-back accepts
      reg_dst = 1'b0; in_valid = 1'b1; imm_signed = 1'b1; instruction = mk(5'd0, 5'd9, 16'h8001);
      next();
      check("lit_imm_signed", FW'(imm_ext),  FW'(32'hFFFF_8001));
      check("lit_dest_rt",    FW'(dest_reg), FW'(5'd9));
      imm_signed = 1'b0;
      next();
      check("lit_imm_zero",   FW'(imm_ext),  FW'(32'h0000_8001));
      in_valid = 1'b0;
      next();
      check("lit_drain",      FW'(out_valid), FW'(0));

      // Back-pressure: stall three cycles, then drain+accept with no bubble
      in_valid = 1'b1; instruction = mk(5'd5, 5'd1, 16'h1234);
      next();
      out_ready = 1'b0; instruction = mk(5'd1, 5'd5, 16'h4321);
      for (int k = 0; k < 3; k++) begin
         next();
         check("lit_stall_ready", FW'(in_ready), FW'(0));
         check("lit_stall_imm",   FW'(imm_ext),  FW'(32'h1234));
      end
      out_ready = 1'b1;
      next();
      check("lit_nobubble_valid", FW'(out_valid),  FW'(1));
      check("lit_nobubble_imm",   FW'(imm_ext),    FW'(32'h4321));
      check("lit_nobubble_rd1",   FW'(read_data1), FW'(32'h1234));
      in_valid = 1'b0;
      next();

      // Same-cycle write and accept on r7
      wr(5'd7, 32'h1111_0000);
`ifdef DECODE_BYPASS_EN
      exp_bypass = 32'hDEAD_BEEF;
`else
      exp_bypass = 32'h1111_0000;
`endif
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
      in_valid = 1'b1; instruction = mk(5'd7, 5'd7, 16'h0);
      next();
      wr_en = 1'b0;
      check("lit_same_cycle_rd0", FW'(read_data0), FW'(exp_bypass));
      check("lit_same_cycle_rd1", FW'(read_data1), FW'(exp_bypass));
      instruction = mk(5'd7, 5'd0, 16'h0);
      next();
      in_valid = 1'b0;
      check("lit_write_done", FW'(read_data0), FW'(32'hDEAD_BEEF));
      out_ready = 1'b0;
      wr(5'd7, 32'h0000_0055);
      check("lit_held_bundle", FW'(read_data0), FW'(32'hDEAD_BEEF));
      out_ready = 1'b1;
      next();

      // Out-of-range and r0 writes ignored; top entry works
      wr(5'd20, 32'd5);
      wr(5'd0,  32'd9);
      wr(5'd15, 32'h0000_ABCD);
      in_valid = 1'b1; instruction = mk(5'd20, 5'd0, 16'h0);
      next();
      check("lit_r20_zero", FW'(read_data0), FW'(0));
      check("lit_r0_zero",  FW'(read_data1), FW'(0));
      instruction = mk(5'd15, 5'd31, 16'h0);
      next();
      in_valid = 1'b0;
      check("lit_r15",      FW'(read_data0), FW'(32'h0000_ABCD));
      check("lit_r31_zero", FW'(read_data1), FW'(0));

      // Mixed traffic
      for (int k = 0; k < 40; k++) begin
         in_valid    = 1'($urandom_range(0, 1));
         out_ready   = ($urandom_range(0, 3) != 0);
         instruction = 26'($urandom);
         reg_dst     = 1'($urandom_range(0, 1));
         imm_signed  = 1'($urandom_range(0, 1));
         wr_en       = 1'($urandom_range(0, 1));
         wr_addr     = 5'($urandom_range(0, 19));
         wr_data     = $urandom;
         next();
      end
      wr_en = 1'b0;

      // Asynchronous reset while a bundle is held
      in_valid = 1'b1; out_ready = 1'b0; instruction = mk(5'd15, 5'd7, 16'h7FFF);
      next();
      in_valid = 1'b0;
      check("lit_pre_reset_valid", FW'(out_valid), FW'(1));
      #2 reset = 1'b0;
      #1;
      check("lit_async_valid", FW'(out_valid),  FW'(0));
      check("lit_async_regs",  io_registers,    '0);
      check("lit_async_rd0",   FW'(read_data0), FW'(0));
      check("lit_async_imm",   FW'(imm_ext),    FW'(0));
      next();
      reset = 1'b1; out_ready = 1'b1;
      next();
      in_valid = 1'b1; instruction = mk(5'd15, 5'd7, 16'h0);
      next();
      in_valid = 1'b0;
      check("lit_post_reset_valid", FW'(out_valid),  FW'(1));
      check("lit_post_reset_rd0",   FW'(read_data0), FW'(0));
      next();
      next();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1);
   end
endmodule
